// File: rtl/dom_and_seq_ctrl_if.sv
// Signal bundle between the DOM AND sequencer, the masked front-end and the gadget.
// The sequencer takes the master view; the surrounding environment takes the slave view.
interface dom_and_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [3:0]       x_i;
    logic [3:0]       y_i;
    logic             rnd_valid_i;
    logic [5:0]       rnd_i;
    logic             rnd_ready_o;
    logic [3:0]       gx_o;
    logic [3:0]       gy_o;
    logic [5:0]       gz_o;
    logic [3:0]       gq_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [3:0]       q_o;
    logic             busy_o;
    logic [CNT_W-1:0] op_cnt_o;

    modport master (
        input  in_valid_i, x_i, y_i, rnd_valid_i, rnd_i, gq_i, out_ready_i,
        output in_ready_o, rnd_ready_o, gx_o, gy_o, gz_o, out_valid_o, q_o,
               busy_o, op_cnt_o
    );

    modport slave (
        output in_valid_i, x_i, y_i, rnd_valid_i, rnd_i, gq_i, out_ready_i,
        input  in_ready_o, rnd_ready_o, gx_o, gy_o, gz_o, out_valid_o, q_o,
               busy_o, op_cnt_o
    );
endinterface

// File: rtl/dom_and_seq_ctrl.sv
// Sequencer for a 4-share DOM AND gadget with one resharing register stage:
// accept operands, fetch 6 random bits, drive the gadget for two cycles, hand out the result.
module dom_and_seq_ctrl #(
    parameter int CNT_W      = 16,
    parameter bit CLEAR_IDLE = 1'b1
) (
    input logic              clk_i,
    input logic              rst_i,
    dom_and_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RND,
        S_LOAD,
        S_EVAL,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       x_q, x_d;
    logic [3:0]       y_q, y_d;
    logic [5:0]       z_q, z_d;
    logic [3:0]       q_q, q_d;
    logic [3:0]       gx_q, gx_d;
    logic [3:0]       gy_q, gy_d;
    logic [5:0]       gz_q, gz_d;
    logic             in_ready_q, in_ready_d;
    logic             rnd_ready_q, rnd_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drive_d;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        q_d     = q_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
                    x_d     = bus.x_i;
                    y_d     = bus.y_i;
                    state_d = S_WAIT_RND;
                end
            end
            S_WAIT_RND: begin
                if (bus.rnd_valid_i) begin
                    z_d     = bus.rnd_i;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                q_d     = bus.gq_i;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.out_ready_i) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_IDLE;
                    // Scrub shares so nothing of this operation lingers in the registers.
                    if (CLEAR_IDLE) begin
                        x_d = '0;
                        y_d = '0;
                        z_d = '0;
                        q_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they settle together with it.
        drive_d     = !CLEAR_IDLE || (state_d == S_LOAD) || (state_d == S_EVAL);
        gx_d        = drive_d ? x_d : '0;
        gy_d        = drive_d ? y_d : '0;
        gz_d        = drive_d ? z_d : '0;
        in_ready_d  = (state_d == S_IDLE);
        rnd_ready_d = (state_d == S_WAIT_RND);
        out_valid_d = (state_d == S_HOLD);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            q_q         <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            gz_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            rnd_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            q_q         <= q_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            gz_q        <= gz_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            rnd_ready_q <= rnd_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.rnd_ready_o = rnd_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.gx_o        = gx_q;
    assign bus.gy_o        = gy_q;
    assign bus.gz_o        = gz_q;
    assign bus.q_o         = q_q;
    assign bus.op_cnt_o    = cnt_q;

endmodule
